mux_scan_ctrl: RTL
==================

Name: mux_scan_ctrl

Overview:
- Sequencer directly upstream/downstream of the 4:1 mux (`mux2`).
- Drives the mux select lines s1/s0 through channels i0..i3 in order.
- Holds each select for a programmable dwell and samples the mux output once per channel.
- Packs the four samples into a 4-bit word with a one-cycle valid strobe. Supports single-shot or continuous scanning.

Parameters:
- DWELL, 4, cycles spent on each channel (settle + sample); legal range 2..255, elaboration-time check.
- CNT_W, 8, width of the dwell counter; must hold DWELL-1.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  begin one scan; sampled only in IDLE.
- continuous  input  1  when 1 at end of scan, restart immediately at channel 0.
- mux_out  input  1  output of the 4:1 mux being scanned.
- s0  output  1  mux select LSB, equals ch[0].
- s1  output  1  mux select MSB, equals ch[1].
- data  output  4  last completed scan; data[k] = mux_out sampled while ch==k.
- valid  output  1  one-cycle strobe, data updated this cycle.
- busy  output  1  high in any state except IDLE.

Behaviour:
- Reset (rst=1 at a rising edge):
  - state=IDLE, ch=0, cnt=0, shadow=0.
  - data=4'b0000, valid=0, busy=0, s1=s0=0.
  - Reset mid-scan discards the partial scan; no valid is issued.
- Register style: all outputs are registered; s1/s0 are decoded directly from the ch register.
- Channel mapping: {s1,s0}=00 selects i0, 01 selects i1, 10 selects i2, 11 selects i3.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - start=1 -> SETTLE, ch=0, cnt=0.
  - start=0 -> stay in IDLE.
- SETTLE:
  - cnt increments every cycle; mux_out is ignored.
  - When cnt==DWELL-2 -> SAMPLE.
  - SETTLE therefore lasts DWELL-1 cycles.
- SAMPLE (exactly one cycle):
  - At the closing edge, shadow[ch] <= mux_out.
  - If ch==3 -> DONE, data <= {mux_out, shadow[2:0]}, valid <= 1.
  - Else ch <= ch+1, cnt <= 0, back to SETTLE.
- DONE (exactly one cycle, valid=1):
  - If continuous=1 -> SETTLE with ch=0, cnt=0.
  - Else -> IDLE with ch=0.
  - valid deasserts on the next edge.
- Latency: if start is sampled at edge E0, valid is high in the cycle following edge E0+4*DWELL.
- Continuous-mode period is 4*DWELL+1 cycles.
- Boundary rules:
  - start while busy: ignored, never queued.
  - continuous deasserted mid-scan: the current scan completes and issues valid, then returns to IDLE.
  - continuous is evaluated only in DONE.
  - ch wraps 3->0 only via DONE, never by increment overflow.
  - data holds its value between valid strobes and is not cleared by returning to IDLE.
  - start and rst together: rst wins.

Optional Feature:
- Macro: SCAN_PARITY_EN.
- Defined:
  - Adds output port parity (1 bit) = XOR of the four bits loaded into data.
  - Registered in the same edge as data; reset value 0.
  - Holds between strobes like data.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset: rst=1 for 2 cycles mid-activity -> s1=s0=0, data=0000, valid=0, busy=0 after the first reset edge.
- Single scan, DWELL=4, bench models mux with i0..i3=0,1,1,0 -> {s1,s0} = 00,01,10,11 each held 4 cycles; valid high for 1 cycle, 16 edges after start; data=4'b0110; busy falls the following cycle.
- Continuous: continuous=1, inputs changed to 1,0,0,1 during the first scan's DONE cycle -> first data=0110, second valid exactly 17 cycles later with data=1001; no gap in the select sequence except the DONE cycle.
- Start while busy: extra start pulses at cycles 3 and 9 of a scan -> exactly one valid pulse, and IDLE is reached after it.
- Reset mid-scan: assert rst while ch=2 -> ch=0, no valid, data keeps the reset value 0000; a new start yields a full 16-cycle scan from channel 0.
- Settle filtering: bench forces mux_out to the inverse of the channel value during SETTLE cycles and the correct value during SAMPLE -> data equals the SAMPLE-cycle values only (0110); with SCAN_PARITY_EN, parity=0.

Source files
------------

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: steps a 4:1 mux through i0..i3 and packs one sample per channel.
// Build option: define SCAN_PARITY_EN to add the registered 'parity' output.
module mux_scan_ctrl #(
    parameter int DWELL = 4,
    parameter int CNT_W = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       continuous,
    input  logic       mux_out,
    output logic       s0,
    output logic       s1,
    output logic [3:0] data,
    output logic       valid,
    output logic       busy
`ifdef SCAN_PARITY_EN
    ,
    output logic       parity
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    if (DWELL < 2 || DWELL > 255) begin : g_bad_dwell
        $error("mux_scan_ctrl: DWELL must be in 2..255");
    end
    if ((DWELL - 1) >= (1 << CNT_W)) begin : g_bad_cnt_w
        $error("mux_scan_ctrl: CNT_W too narrow for DWELL-1");
    end

    state_t           state, state_n;
    logic [1:0]       ch, ch_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       shadow, shadow_n;
    logic [3:0]       data_n;
    logic             valid_n;

    // Next-state and datapath decode for the scan sequence
    always_comb begin
        state_n  = state;
        ch_n     = ch;
        cnt_n    = cnt;
        shadow_n = shadow;
        data_n   = data;
        valid_n  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_n = SETTLE;
                    ch_n    = 2'd0;
                    cnt_n   = '0;
                end
            end
            SETTLE: begin
                cnt_n = cnt + 1'b1;
                if (cnt == CNT_W'(DWELL - 2)) begin
                    state_n = SAMPLE;
                end
            end
            SAMPLE: begin
                if (ch == 2'd3) begin
                    state_n = DONE;
                    data_n  = {mux_out, shadow};
                    valid_n = 1'b1;
                end else begin
                    shadow_n[ch] = mux_out;
                    ch_n         = ch + 2'd1;
                    cnt_n        = '0;
                    state_n      = SETTLE;
                end
            end
            DONE: begin
                ch_n    = 2'd0;
                cnt_n   = '0;
                state_n = continuous ? SETTLE : IDLE;
            end
        endcase
    end

    // State and output registers; reset discards any partial scan
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            ch     <= 2'd0;
            cnt    <= '0;
            shadow <= 3'b000;
            data   <= 4'b0000;
            valid  <= 1'b0;
            busy   <= 1'b0;
        end else begin
            state  <= state_n;
            ch     <= ch_n;
            cnt    <= cnt_n;
            shadow <= shadow_n;
            data   <= data_n;
            valid  <= valid_n;
            busy   <= (state_n != IDLE);
        end
    end

`ifdef SCAN_PARITY_EN
    // Parity of the word loaded into data, updated on the same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            parity <= 1'b0;
        end else if (valid_n) begin
            parity <= ^data_n;
        end
    end
`endif

    assign s0 = ch[0];
    assign s1 = ch[1];

endmodule
